result_shift_out: RTL and testbench
===================================

# result_shift_out

Parallel-to-serial drain for ALU result words. It accepts one WIDTH-bit word from the result register over a valid/ready load handshake and emits it one bit per accepted transfer on a valid/ready serial handshake. It marks the first and last bit of each frame and pulses `done` when the frame completes. It sits after the result register, at the output end of the datapath, and feeds bit-serial consumers such as a debug or output pin driver.

## Interface
- `WIDTH`, 8, word width in bits; legal range ≥ 2.
- `MSB_FIRST`, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

- `clk`  input  1  rising-edge clock; all state changes on this edge.
- `reset`  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `load_valid`  input  1  upstream has a word on `load_data`.
- `load_ready`  output  1  block can accept a word.
- `load_data`  input  WIDTH  word to serialize; sampled only on load handshake.
- `serial_out`  output  1  current bit.
- `serial_valid`  output  1  `serial_out` holds a valid bit.
- `serial_ready`  input  1  downstream accepts the current bit this cycle.
- `serial_first`  output  1  current bit is the first of the frame.
- `serial_last`  output  1  current bit is the last of the frame.
- `done`  output  1  one-cycle pulse after the last bit is accepted.

## Operation
- There are two states: IDLE and SHIFT.
- IDLE:
  - `load_ready`=1 and `serial_valid`=0.
  - On `load_valid`&&`load_ready`: capture `load_data` into the shift register, set `bit_cnt`=WIDTH-1, and go to SHIFT.
- SHIFT:
  - `load_ready`=0 and `serial_valid`=1.
  - `serial_out` = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - `serial_first`=1 only while no bit of the current frame has yet been accepted.
  - `serial_last`=1 when `bit_cnt`==0.
- Serial transfer occurs on `serial_valid`&&`serial_ready`:
  - The register shifts toward the output end, filling with 0.
  - `bit_cnt` decrements.
  - If the transfer was the last bit: go to IDLE and assert `done` for exactly the next cycle.
- Backpressure: while `serial_valid`&&!`serial_ready`, `serial_out`, `serial_first`, `serial_last` and internal state hold unchanged indefinitely.
- `load_valid` while in SHIFT is not accepted. Upstream must hold the word until `load_ready`. The block never drops or double-captures a word.
- `bit_cnt` width is clog2(WIDTH). It never wraps: the last-bit transfer exits SHIFT before decrementing below 0.
- When `serial_valid`=0, `serial_out`, `serial_first` and `serial_last` drive 0.
- All outputs are derived from registered state. There is no combinational path from `load_valid` or `serial_ready` to any output.

## Timing
- Reset values, effective the cycle after `reset` is sampled high:
  - state = IDLE, `load_ready`=1
  - `serial_valid`=0, `serial_out`=0, `serial_first`=0, `serial_last`=0
  - `done`=0, shift register = 0, `bit_cnt` = 0
- Reset takes priority over all handshakes in the same cycle.
- Reset mid-frame: the word is abandoned and no `done` pulse is produced.
- Load latency: a word accepted at edge N gives its first bit valid in the cycle after edge N.
- With `serial_ready` tied 1:
  - A frame occupies WIDTH cycles of `serial_valid`.
  - `done` is high in the cycle after the last bit.
  - `load_ready` is high in that same cycle.
  - Minimum word period is WIDTH+1 cycles (one IDLE bubble between frames).
- `done` and a new load handshake may occur in the same cycle.

## Test plan
- WIDTH=8, MSB_FIRST=1, load 8'hA5, `serial_ready`=1:
  - `serial_out` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
  - `serial_first` on bit 1 only; `serial_last` on bit 8 only.
  - `done` pulses 1 cycle later, together with `load_ready`=1.
- MSB_FIRST=0, load 8'h01: bits are 1,0,0,0,0,0,0,0.
- Backpressure: load 8'hC3 and drop `serial_ready` for 3 cycles after the 2nd bit:
  - The 3rd bit (0) holds stable for 3 cycles.
  - The full frame spans 11 cycles and the bit sequence is unchanged.
- Back-to-back: `load_valid` held high with 8'hF0 during an active frame:
  - It is not accepted until the IDLE cycle.
  - The second frame starts exactly 1 cycle after the first frame's last bit.
- Reset asserted during bit 4 of 8'h5A:
  - Next cycle `serial_valid`=0, `load_ready`=1, and no `done`.
  - A subsequent load of 8'hFF serializes 8 ones correctly.
- WIDTH=4, load 4'b1001: 4-bit frame, `serial_last` on the 4th bit, `done` on cycle 5.

Source files
------------

// File: rtl/result_shift_out.sv
// result_shift_out: parallel-to-serial drain for ALU result words.
// Takes one WIDTH-bit word over a load valid/ready handshake and emits it
// one bit per serial valid/ready transfer, flagging the first and last bit
// of each frame and pulsing done once the last bit has been taken.
module result_shift_out #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             serial_out,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             serial_first,
    output logic             serial_last,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    bit_cnt_q;
    logic             first_q;
    logic             done_q;
    logic             ready_q;
    logic             valid_q;
    logic             out_bit;

    // Output end of the register depends on bit order; shifting moves the
    // next bit toward that end and back-fills with zero.
    assign out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                               : {1'b0, shreg_q[WIDTH-1:1]};

    // Frame control FSM; handshake flags are registered alongside the state
    // so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            first_q   <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_valid) begin
                        shreg_q   <= load_data;
                        bit_cnt_q <= CNT_LAST;
                        first_q   <= 1'b1;
                        ready_q   <= 1'b0;
                        valid_q   <= 1'b1;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (serial_ready) begin
                        shreg_q <= shreg_d;
                        first_q <= 1'b0;
                        if (bit_cnt_q == '0) begin
                            // Last bit taken: leave before the counter can wrap.
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            valid_q <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign load_ready   = ready_q;
    assign serial_valid = valid_q;
    assign serial_out   = valid_q & out_bit;
    assign serial_first = valid_q & first_q;
    assign serial_last  = valid_q & (bit_cnt_q == '0);
    assign done         = done_q;

endmodule

// File: tb/tb_result_shift_out.sv
// Directed bench for result_shift_out: three instances cover 8-bit
// MSB-first, 8-bit LSB-first and 4-bit MSB-first frames.
module tb_result_shift_out;

    logic       clk;
    logic       reset;
    logic [2:0] lv;
    logic [2:0] lr;
    logic [7:0] ld [3];
    logic [2:0] so;
    logic [2:0] sv;
    logic [2:0] sr;
    logic [2:0] sf;
    logic [2:0] sl;
    logic [2:0] dn;

    int nvec;
    int nerr;

    result_shift_out #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
        .clk(clk), .reset(reset),
        .load_valid(lv[0]), .load_ready(lr[0]), .load_data(ld[0]),
        .serial_out(so[0]), .serial_valid(sv[0]), .serial_ready(sr[0]),
        .serial_first(sf[0]), .serial_last(sl[0]), .done(dn[0])
    );

    result_shift_out #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
        .clk(clk), .reset(reset),
        .load_valid(lv[1]), .load_ready(lr[1]), .load_data(ld[1]),
        .serial_out(so[1]), .serial_valid(sv[1]), .serial_ready(sr[1]),
        .serial_first(sf[1]), .serial_last(sl[1]), .done(dn[1])
    );

    result_shift_out #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb4 (
        .clk(clk), .reset(reset),
        .load_valid(lv[2]), .load_ready(lr[2]), .load_data(ld[2][3:0]),
        .serial_out(so[2]), .serial_valid(sv[2]), .serial_ready(sr[2]),
        .serial_first(sf[2]), .serial_last(sl[2]), .done(dn[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle-side outputs of one instance.
    task automatic chk_idle(input int d, input logic exp_done);
        chk("idle_ready", 32'(lr[d]), 32'd1);
        chk("idle_valid", 32'(sv[d]), 32'd0);
        chk("idle_out",   32'(so[d]), 32'd0);
        chk("idle_first", 32'(sf[d]), 32'd0);
        chk("idle_last",  32'(sl[d]), 32'd0);
        chk("idle_done",  32'(dn[d]), 32'(exp_done));
    endtask

    // Present one word for a single accepting edge.
    task automatic load(input int d, input logic [7:0] data);
        chk("load_ready", 32'(lr[d]), 32'd1);
        lv[d] = 1'b1;
        ld[d] = data;
        step();
        lv[d] = 1'b0;
    endtask

    // Walk a frame from its first bit; seq lists expected bits left to right
    // in its low n bits. Ends in the done cycle.
    task automatic run_frame(input int d, input logic [7:0] seq, input int n,
                             input int stall_at, input int stall_len);
        int vc;
        vc = 0;
        for (int i = 0; i < n; i++) begin
            chk("bit_valid", 32'(sv[d]), 32'd1);
            chk("bit_out",   32'(so[d]), 32'(seq[n-1-i]));
            chk("bit_first", 32'(sf[d]), 32'(i == 0));
            chk("bit_last",  32'(sl[d]), 32'(i == n - 1));
            chk("bit_ready", 32'(lr[d]), 32'd0);
            chk("bit_done",  32'(dn[d]), 32'd0);
            vc++;
            if (i == stall_at) begin
                sr[d] = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    vc++;
                    chk("hold_valid", 32'(sv[d]), 32'd1);
                    chk("hold_out",   32'(so[d]), 32'(seq[n-1-i]));
                    chk("hold_first", 32'(sf[d]), 32'(i == 0));
                    chk("hold_last",  32'(sl[d]), 32'(i == n - 1));
                end
                sr[d] = 1'b1;
            end
            step();
        end
        chk("frame_len", 32'(vc), 32'(n + stall_len));
        chk_idle(d, 1'b1);
    endtask

    initial begin
        nvec  = 0;
        nerr  = 0;
        reset = 1'b1;
        lv    = '0;
        sr    = '1;
        for (int k = 0; k < 3; k++) ld[k] = 8'h00;

        repeat (2) step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) chk_idle(k, 1'b0);

        // MSB-first A5 with ready tied high.
        load(0, 8'hA5);
        run_frame(0, 8'b1010_0101, 8, -1, 0);
        step();
        chk("done_pulse_end", 32'(dn[0]), 32'd0);

        // LSB-first 01: single one comes out first.
        load(1, 8'h01);
        run_frame(1, 8'b1000_0000, 8, -1, 0);
        step();
        chk("lsb_done_end", 32'(dn[1]), 32'd0);

        // Backpressure on the third bit of C3.
        load(0, 8'hC3);
        run_frame(0, 8'b1100_0011, 8, 2, 3);
        step();

        // Back-to-back: F0 held on load during an active A5 frame.
        load(0, 8'hA5);
        lv[0] = 1'b1;
        ld[0] = 8'hF0;
        run_frame(0, 8'b1010_0101, 8, -1, 0);
        step();
        lv[0] = 1'b0;
        run_frame(0, 8'b1111_0000, 8, -1, 0);
        step();
        chk("b2b_no_reload", 32'(sv[0]), 32'd0);

        // Reset during bit 4 of 5A, then a clean FF frame.
        load(0, 8'h5A);
        for (int i = 0; i < 3; i++) step();
        chk("rst_bit4_out", 32'(so[0]), 32'd1);
        chk("rst_bit4_vld", 32'(sv[0]), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle(0, 1'b0);
        step();
        chk("rst_no_done", 32'(dn[0]), 32'd0);
        load(0, 8'hFF);
        run_frame(0, 8'b1111_1111, 8, -1, 0);
        step();

        // 4-bit instance, 1001.
        load(2, 8'h09);
        run_frame(2, 8'b0000_1001, 4, -1, 0);
        step();
        chk("w4_done_end", 32'(dn[2]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
